writeback_stage: RTL

- Final pipeline stage of the CPU; sits directly upstream of the regfile write port.
- Captures one retiring instruction per cycle from the memory stage and selects ALU result or load data.
- Performs byte/half load extraction with sign/zero extension, then drives write_register/write_data/reg_write into the regfile.
- Also exports a forwarding copy for the decode stage, a retire counter and a sticky misalignment flag.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/writeback_stage_if.sv | 28 ++
 rtl/load_extend.sv | 39 +++
 rtl/writeback_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types for the writeback stage and its load extender
package cpu_pkg;

    localparam int WORD       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } load_size_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  misaligned;
        logic [WORD-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - memory-stage to writeback-stage handshake bundle
// master: memory stage drives in_valid and payload, receives in_ready
// slave : writeback stage receives payload, drives in_ready
interface writeback_stage_if;
    import cpu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic [WORD-1:0]       in_alu_result;
    logic [WORD-1:0]       in_mem_data;
    logic [1:0]            in_load_size;
    logic                  in_load_unsigned;

    modport master (
        output in_valid, in_rd, in_reg_write, in_mem_to_reg,
               in_alu_result, in_mem_data, in_load_size, in_load_unsigned,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_mem_to_reg,
               in_alu_result, in_mem_data, in_load_size, in_load_unsigned,
        output in_ready
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte/half/word load extraction with sign/zero extension
// inputs : mem_data (aligned word), offset (address[1:0]), size, load_unsigned
// outputs: data (extended result), misaligned (half at odd offset, word at nonzero offset)
module load_extend
    import cpu_pkg::*;
(
    input  logic [WORD-1:0] mem_data,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            load_unsigned,
    output logic [WORD-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = mem_data[{offset, 3'b000} +: 8];
        half_v     = offset[1] ? mem_data[31:16] : mem_data[15:0];
        data       = mem_data;
        misaligned = 1'b0;
        case (size)
            LS_BYTE: begin
                data = load_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            LS_HALF: begin
                data       = load_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
                misaligned = offset[0];
            end
            default: begin
                // Reserved size 3 behaves as a word load.
                data       = mem_data;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: one-entry retire buffer driving the regfile
// ports: clk, reset_n (async active-low), in_bus (slave handshake from memory stage),
//        hold, flush, write_register/write_data/reg_write (regfile),
//        fwd_valid/fwd_rd/fwd_data (decode forwarding), retire_count, misalign_err
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int WORD    = cpu_pkg::WORD,
    parameter int COUNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    writeback_stage_if.slave      in_bus,
    input  logic                  hold,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] write_register,
    output logic [WORD-1:0]       write_data,
    output logic                  reg_write,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [WORD-1:0]       fwd_data,
    output logic [COUNT_W-1:0]    retire_count,
    output logic                  misalign_err
);

    wb_state_t          state_q, state_d;
    wb_entry_t          entry_q, entry_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;

    wb_entry_t          entry_new;
    logic [WORD-1:0]    ext_data;
    logic               ext_misaligned;
    logic               capture;
    logic               retire;

    load_extend u_load_extend (
        .mem_data      (in_bus.in_mem_data),
        .offset        (in_bus.in_alu_result[1:0]),
        .size          (in_bus.in_load_size),
        .load_unsigned (in_bus.in_load_unsigned),
        .data          (ext_data),
        .misaligned    (ext_misaligned)
    );

    assign in_bus.in_ready = !hold || (state_q == ST_EMPTY);
    assign capture         = in_bus.in_valid && in_bus.in_ready && !flush;
    assign retire          = (state_q == ST_FULL) && !hold;

    always_comb begin
        entry_new            = '0;
        entry_new.rd         = in_bus.in_rd;
        entry_new.reg_write  = in_bus.in_reg_write;
        entry_new.misaligned = in_bus.in_mem_to_reg && ext_misaligned;
        entry_new.data       = in_bus.in_mem_to_reg ? ext_data : in_bus.in_alu_result;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            entry_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; flush dominates capture, capture replaces a retiring entry.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_EMPTY;
            entry_d = '0;
        end else begin
            if (retire) begin
                count_d = count_q + 1'b1;
            end
            if (capture) begin
                state_d = ST_FULL;
                entry_d = entry_new;
                err_d   = err_q || entry_new.misaligned;
            end else if (retire) begin
                state_d = ST_EMPTY;
                entry_d = '0;
            end
        end
    end

    // Output logic
    always_comb begin
        write_register = entry_q.rd;
        write_data     = entry_q.data;
        fwd_rd         = entry_q.rd;
        fwd_data       = entry_q.data;
        fwd_valid      = (state_q == ST_FULL) && entry_q.reg_write && !entry_q.misaligned;
        reg_write      = fwd_valid && !hold;
        retire_count   = count_q;
        misalign_err   = err_q;
    end

endmodule
